// File: rtl/key_expansion_seq.sv
// Sequential AES key schedule for AES-128/192/256 (selected by NK).
// One schedule word per clock from a single shared SubWord unit; full schedule on w, computed words streamed on wr_*.
module key_expansion_seq #(
  parameter int NK = 4,
  parameter int NR = NK + 6,
  parameter int NW = 4 * (NR + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [0:32*NK-1]      key,
  output logic                  busy,
  output logic                  done,
  output logic                  w_valid,
  output logic [0:128*(NR+1)-1] w,
  output logic                  wr_en,
  output logic [5:0]            wr_addr,
  output logic [31:0]           wr_word
);

  generate
    if (!((NK == 4) || (NK == 6) || (NK == 8)) || (NR != NK + 6) || (NW != 4 * (NR + 1))) begin : g_bad_param
      $error("key_expansion_seq: NK must be 4, 6 or 8; NR and NW are derived and must not be overridden");
    end
  endgenerate

  localparam logic [5:0] NK_IDX     = 6'(NK);
  localparam logic [5:0] LAST_IDX   = 6'(NW - 1);
  localparam logic [2:0] PHASE_WRAP = 3'(NK - 1);
  localparam bit         MID_SUB    = (NK == 8);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t      state_reg, state_next;
  logic        load_key, step, finish;
  logic [5:0]  i_reg;
  logic [2:0]  phase_reg;
  logic [7:0]  rcon_reg;
  logic [31:0] window_reg [NK];
  logic [31:0] sched_reg  [NW];
  logic [31:0] key_word   [NK];
  logic [31:0] prev_word, sub_in, sub_out, temp_word, new_word;

  // window_reg holds w[i-NK..i-1], oldest at index 0, so no wide read mux is needed.
  genvar gi;
  generate
    for (gi = 0; gi < NK; gi++) begin : g_key
      assign key_word[gi] = key[32*gi +: 32];
    end
    for (gi = 0; gi < NW; gi++) begin : g_flat
      assign w[32*gi +: 32] = sched_reg[gi];
    end
    for (gi = 0; gi < 4; gi++) begin : g_sub
      assign sub_out[8*gi +: 8] = SBOX[sub_in[8*gi +: 8]];
    end
  endgenerate

  assign prev_word = window_reg[NK-1];
  assign sub_in    = (phase_reg == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

  always_comb begin
    temp_word = prev_word;
    if (phase_reg == 3'd0) begin
      temp_word = sub_out ^ {rcon_reg, 24'h000000};
    end else if (MID_SUB && (phase_reg == 3'd4)) begin
      temp_word = sub_out;
    end
  end

  assign new_word = window_reg[0] ^ temp_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load_key   = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          load_key   = 1'b1;
          state_next = EXPAND;
        end
      end
      EXPAND: begin
        step = 1'b1;
        if (i_reg == LAST_IDX) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      w_valid   <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= 6'd0;
      wr_word   <= 32'd0;
      i_reg     <= 6'd0;
      phase_reg <= 3'd0;
      rcon_reg  <= 8'h01;
      for (int k = 0; k < NK; k++) window_reg[k] <= 32'd0;
      for (int k = 0; k < NW; k++) sched_reg[k] <= 32'd0;
    end else begin
      done  <= 1'b0;
      wr_en <= 1'b0;
      if (load_key) begin
        for (int k = 0; k < NK; k++) begin
          sched_reg[k]  <= key_word[k];
          window_reg[k] <= key_word[k];
        end
        i_reg     <= NK_IDX;
        phase_reg <= 3'd0;
        rcon_reg  <= 8'h01;
        w_valid   <= 1'b0;
        busy      <= 1'b1;
      end
      if (step) begin
        sched_reg[i_reg] <= new_word;
        for (int k = 0; k < NK - 1; k++) window_reg[k] <= window_reg[k+1];
        window_reg[NK-1] <= new_word;
        wr_en     <= 1'b1;
        wr_addr   <= i_reg;
        wr_word   <= new_word;
        i_reg     <= i_reg + 6'd1;
        phase_reg <= (phase_reg == PHASE_WRAP) ? 3'd0 : phase_reg + 3'd1;
        // Rcon advances only when it has just been consumed.
        if (phase_reg == 3'd0) begin
          rcon_reg <= {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);
        end
        if (finish) begin
          busy    <= 1'b0;
          done    <= 1'b1;
          w_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_key_expansion_seq.sv
// Self-checking bench for key_expansion_seq: three instances (NK=4/6/8) checked against
// a textbook key-schedule model whose S-box is derived from GF(2^8) inversion.
module tb_key_expansion_seq;

  localparam logic [255:0] K4 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K6 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start4, start6, start8;
  logic [0:127] key4;
  logic [0:191] key6;
  logic [0:255] key8;
  logic busy4, done4, wv4, wr_en4, busy6, done6, wv6, wr_en6, busy8, done8, wv8, wr_en8;
  logic [0:1407] w4;
  logic [0:1663] w6;
  logic [0:1919] w8;
  logic [5:0] wr_addr4, wr_addr6, wr_addr8;
  logic [31:0] wr_word4, wr_word6, wr_word8;

  key_expansion_seq #(.NK(4)) dut4 (.clk(clk), .reset(reset), .start(start4), .key(key4), .busy(busy4),
    .done(done4), .w_valid(wv4), .w(w4), .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_word(wr_word4));
  key_expansion_seq #(.NK(6)) dut6 (.clk(clk), .reset(reset), .start(start6), .key(key6), .busy(busy6),
    .done(done6), .w_valid(wv6), .w(w6), .wr_en(wr_en6), .wr_addr(wr_addr6), .wr_word(wr_word6));
  key_expansion_seq #(.NK(8)) dut8 (.clk(clk), .reset(reset), .start(start8), .key(key8), .busy(busy8),
    .done(done8), .w_valid(wv8), .w(w8), .wr_en(wr_en8), .wr_addr(wr_addr8), .wr_word(wr_word8));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stream / done monitors
  int          a4_q[$], a6_q[$], a8_q[$];
  logic [31:0] d4_q[$], d6_q[$], d8_q[$];
  int          done4_q[$], done6_q[$], done8_q[$];
  logic [31:0] w43_q[$];

  always @(negedge clk) begin
    if (wr_en4) begin a4_q.push_back(int'(wr_addr4)); d4_q.push_back(wr_word4); end
    if (wr_en6) begin a6_q.push_back(int'(wr_addr6)); d6_q.push_back(wr_word6); end
    if (wr_en8) begin a8_q.push_back(int'(wr_addr8)); d8_q.push_back(wr_word8); end
    if (done4) begin done4_q.push_back(cyc); w43_q.push_back(w4[32*43 +: 32]); end
    if (done6) done6_q.push_back(cyc);
    if (done8) done8_q.push_back(cyc);
  end

  // ---------------- reference model ----------------
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sbox_t[v[31:24]], sbox_t[v[23:16]], sbox_t[v[15:8]], sbox_t[v[7:0]]};
  endfunction

  function automatic void expand(input int nk, input logic [255:0] k, output logic [31:0] ws [60]);
    int nw = 4 * (nk + 7);
    logic [31:0] t;
    logic [7:0] rc;
    for (int i = 0; i < 60; i++) ws[i] = 32'h0;
    for (int i = 0; i < nk; i++) ws[i] = k[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = ws[i-1];
      if (i % nk == 0) begin
        rc = 8'h01;
        for (int r = 1; r < i / nk; r++) rc = gmul(rc, 8'h02);
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      ws[i] = ws[i-nk] ^ t;
    end
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic clear_q();
    a4_q.delete(); a6_q.delete(); a8_q.delete(); d4_q.delete(); d6_q.delete(); d8_q.delete();
    done4_q.delete(); done6_q.delete(); done8_q.delete(); w43_q.delete();
  endtask

  task automatic pulse_all(input logic [255:0] k, input bit en4, input bit en6, input bit en8, output int sc);
    @(negedge clk);
    key4 = k[255:128]; key6 = k[255:64]; key8 = k;
    start4 = en4; start6 = en6; start8 = en8;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
    sc = cyc;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
    key4 = '0; key6 = '0; key8 = '0;
    repeat (3) @(negedge clk);
    checks++; if ({busy4, done4, wv4, wr_en4} !== 4'b0) begin errors++; $display("FAIL reset_ctrl4: got %b expected 0000", {busy4, done4, wv4, wr_en4}); end
    checks++; if ({wr_addr4, wr_word4} !== 38'h0) begin errors++; $display("FAIL reset_wr4: got %h/%h expected 0/0", wr_addr4, wr_word4); end
    checks++; if (w4 !== '0) begin errors++; $display("FAIL reset_w4: w not zero"); end
    checks++; if ({busy6, done6, wv6, wr_en6, busy8, done8, wv8, wr_en8} !== 8'b0) begin errors++; $display("FAIL reset_ctrl68: got %b expected 0", {busy6, done6, wv6, wr_en6, busy8, done8, wv8, wr_en8}); end
    checks++; if (w6 !== '0 || w8 !== '0 || wr_addr6 !== 6'd0 || wr_word8 !== 32'd0) begin errors++; $display("FAIL reset_w68: outputs not zero"); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy4 !== 1'b0 || wr_en4 !== 1'b0) begin errors++; $display("FAIL idle_no_start: busy=%b wr_en=%b expected 0/0", busy4, wr_en4); end
    $display("test_reset done");
  endtask

  task automatic test_nk4_vector();
    logic [31:0] ref_w [60];
    int sc, bad;
    expand(4, K4, ref_w);
    clear_q();
    pulse_all(K4, 1, 0, 0, sc);
    checks++; if (busy4 !== 1'b1 || wv4 !== 1'b0) begin errors++; $display("FAIL nk4_busy: busy=%b w_valid=%b expected 1/0", busy4, wv4); end
    repeat (42) @(negedge clk);
    checks++; if (a4_q.size() != 40) begin errors++; $display("FAIL nk4_stream_len: got %0d expected 40", a4_q.size()); end
    if (a4_q.size() > 0) begin
      checks++; if (a4_q[0] != 4 || d4_q[0] !== 32'ha0fafe17) begin errors++; $display("FAIL nk4_first_wr: got %0d/%h expected 4/a0fafe17", a4_q[0], d4_q[0]); end
    end
    checks++; if (done4_q.size() != 1 || done4_q[0] - sc != 40) begin errors++; $display("FAIL nk4_latency: got %0d pulses, first at %0d expected 1 at 40", done4_q.size(), done4_q.size() ? done4_q[0] - sc : -1); end
    checks++; if (w4[32*43 +: 32] !== 32'hb6630ca6) begin errors++; $display("FAIL nk4_w43: got %h expected b6630ca6", w4[32*43 +: 32]); end
    checks++; if (wv4 !== 1'b1 || busy4 !== 1'b0) begin errors++; $display("FAIL nk4_valid: w_valid=%b busy=%b expected 1/0", wv4, busy4); end
    bad = 0;
    for (int i = 0; i < 44; i++) if (w4[32*i +: 32] !== ref_w[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL nk4_schedule: %0d words differ from model, expected 0", bad); end
    $display("test_nk4_vector: w4=%h w43=%h", w4[32*4 +: 32], w4[32*43 +: 32]);
  endtask

  task automatic test_nk6_vector();
    logic [31:0] ref_w [60];
    int sc, bad;
    expand(6, K6, ref_w);
    clear_q();
    pulse_all(K6, 0, 1, 0, sc);
    repeat (48) @(negedge clk);
    checks++; if (w6[32*6 +: 32] !== 32'hfe0c91f7) begin errors++; $display("FAIL nk6_w6: got %h expected fe0c91f7", w6[32*6 +: 32]); end
    checks++; if (w6[32*51 +: 32] !== 32'h01002202) begin errors++; $display("FAIL nk6_w51: got %h expected 01002202", w6[32*51 +: 32]); end
    checks++; if (done6_q.size() != 1 || done6_q[0] - sc != 46) begin errors++; $display("FAIL nk6_latency: got %0d pulses, first at %0d expected 1 at 46", done6_q.size(), done6_q.size() ? done6_q[0] - sc : -1); end
    checks++; if (a6_q.size() != 46 || wv6 !== 1'b1) begin errors++; $display("FAIL nk6_stream: got len %0d valid %b expected 46/1", a6_q.size(), wv6); end
    bad = 0;
    for (int i = 0; i < 52; i++) if (w6[32*i +: 32] !== ref_w[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL nk6_schedule: %0d words differ from model, expected 0", bad); end
    $display("test_nk6_vector: w6=%h w51=%h", w6[32*6 +: 32], w6[32*51 +: 32]);
  endtask

  task automatic test_nk8_vector();
    logic [31:0] ref_w [60];
    int sc, bad;
    expand(8, K8, ref_w);
    clear_q();
    pulse_all(K8, 0, 0, 1, sc);
    repeat (54) @(negedge clk);
    checks++; if (w8[32*8 +: 32] !== 32'h9ba35411) begin errors++; $display("FAIL nk8_w8: got %h expected 9ba35411", w8[32*8 +: 32]); end
    checks++; if (w8[32*12 +: 32] !== 32'ha8b09c1a) begin errors++; $display("FAIL nk8_w12: got %h expected a8b09c1a", w8[32*12 +: 32]); end
    checks++; if (w8[32*59 +: 32] !== 32'h706c631e) begin errors++; $display("FAIL nk8_w59: got %h expected 706c631e", w8[32*59 +: 32]); end
    checks++; if (done8_q.size() != 1 || done8_q[0] - sc != 52) begin errors++; $display("FAIL nk8_latency: got %0d pulses, first at %0d expected 1 at 52", done8_q.size(), done8_q.size() ? done8_q[0] - sc : -1); end
    bad = 0;
    for (int i = 0; i < 60; i++) if (w8[32*i +: 32] !== ref_w[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL nk8_schedule: %0d words differ from model, expected 0", bad); end
    $display("test_nk8_vector: w8=%h w12=%h w59=%h", w8[32*8 +: 32], w8[32*12 +: 32], w8[32*59 +: 32]);
  endtask

  task automatic test_ignored_start();
    logic [31:0] ref_w [60];
    int sc, bad;
    expand(4, K4, ref_w);
    clear_q();
    pulse_all(K4, 1, 0, 0, sc);
    repeat (9) @(negedge clk);
    key4 = 128'h000102030405060708090a0b0c0d0e0f; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    repeat (35) @(negedge clk);
    checks++; if (done4_q.size() != 1 || done4_q[0] - sc != 40) begin errors++; $display("FAIL ign_latency: got %0d pulses, first at %0d expected 1 at 40", done4_q.size(), done4_q.size() ? done4_q[0] - sc : -1); end
    bad = 0;
    for (int k = 0; k < a4_q.size(); k++) if (a4_q[k] != k + 4 || d4_q[k] !== ref_w[k+4]) bad++;
    checks++; if (a4_q.size() != 40 || bad != 0) begin errors++; $display("FAIL ign_stream: len %0d with %0d bad entries, expected 40 and 0", a4_q.size(), bad); end
    checks++; if (w4[32*43 +: 32] !== 32'hb6630ca6) begin errors++; $display("FAIL ign_w43: got %h expected b6630ca6", w4[32*43 +: 32]); end
    $display("test_ignored_start: stream len %0d", a4_q.size());
  endtask

  task automatic test_reset_mid();
    logic [31:0] ref_w [60];
    int sc, bad;
    expand(4, K4, ref_w);
    clear_q();
    pulse_all(K4, 1, 0, 0, sc);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (busy4 !== 1'b0 || wv4 !== 1'b0 || done4 !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: busy=%b valid=%b done=%b expected 0/0/0", busy4, wv4, done4); end
    checks++; if (w4 !== '0) begin errors++; $display("FAIL rst_mid_w: w not cleared"); end
    repeat (30) @(negedge clk);
    checks++; if (done4_q.size() != 0 || a4_q.size() != 19) begin errors++; $display("FAIL rst_mid_abort: got %0d done, %0d writes expected 0 and 19", done4_q.size(), a4_q.size()); end
    clear_q();
    pulse_all(K4, 1, 0, 0, sc);
    repeat (42) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 44; i++) if (w4[32*i +: 32] !== ref_w[i]) bad++;
    checks++; if (bad != 0 || done4_q.size() != 1 || wv4 !== 1'b1) begin errors++; $display("FAIL rst_mid_rerun: %0d bad words, %0d done, valid %b expected 0/1/1", bad, done4_q.size(), wv4); end
    $display("test_reset_mid: rerun w43=%h", w4[32*43 +: 32]);
  endtask

  task automatic test_back_to_back();
    int bad;
    clear_q();
    @(negedge clk);
    key4 = K4[255:128]; start4 = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (wv4 !== 1'b0 || busy4 !== 1'b1) begin errors++; $display("FAIL b2b_midrun: valid=%b busy=%b expected 0/1", wv4, busy4); end
    repeat (110) @(negedge clk);
    start4 = 1'b0;
    repeat (45) @(negedge clk);
    bad = 0;
    for (int k = 1; k < done4_q.size(); k++) if (done4_q[k] - done4_q[k-1] != 41) bad++;
    checks++; if (done4_q.size() < 3 || bad != 0) begin errors++; $display("FAIL b2b_spacing: %0d pulses, %0d gaps not 41, expected >=3 and 0", done4_q.size(), bad); end
    bad = 0;
    foreach (w43_q[k]) if (w43_q[k] !== 32'hb6630ca6) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_w43: %0d runs with w43 != b6630ca6, expected 0", bad); end
    $display("test_back_to_back: %0d runs", done4_q.size());
  endtask

  task automatic test_random_keys();
    logic [31:0] r4 [60], r6 [60], r8 [60];
    logic [255:0] k;
    int sc, bad4, bad6, bad8, sbad;
    for (int it = 0; it < 4; it++) begin
      for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
      expand(4, k, r4); expand(6, k, r6); expand(8, k, r8);
      clear_q();
      pulse_all(k, 1, 1, 1, sc);
      key4 = ~key4; key6 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}; key8 = ~key8;
      repeat (54) @(negedge clk);
      bad4 = 0; bad6 = 0; bad8 = 0; sbad = 0;
      for (int i = 0; i < 44; i++) if (w4[32*i +: 32] !== r4[i]) bad4++;
      for (int i = 0; i < 52; i++) if (w6[32*i +: 32] !== r6[i]) bad6++;
      for (int i = 0; i < 60; i++) if (w8[32*i +: 32] !== r8[i]) bad8++;
      for (int q = 0; q < d8_q.size(); q++) if (a8_q[q] != q + 8 || d8_q[q] !== r8[q+8]) sbad++;
      checks++; if (bad4 != 0) begin errors++; $display("FAIL rnd%0d_nk4: %0d words differ, expected 0", it, bad4); end
      checks++; if (bad6 != 0) begin errors++; $display("FAIL rnd%0d_nk6: %0d words differ, expected 0", it, bad6); end
      checks++; if (bad8 != 0) begin errors++; $display("FAIL rnd%0d_nk8: %0d words differ, expected 0", it, bad8); end
      checks++; if (d8_q.size() != 52 || sbad != 0) begin errors++; $display("FAIL rnd%0d_stream8: len %0d bad %0d expected 52/0", it, d8_q.size(), sbad); end
      checks++; if (done4_q.size() != 1 || done6_q.size() != 1 || done8_q.size() != 1 ||
                    done4_q[0] - sc != 40 || done6_q[0] - sc != 46 || done8_q[0] - sc != 52) begin
        errors++; $display("FAIL rnd%0d_latency: pulse counts %0d/%0d/%0d expected 1/1/1 at 40/46/52", it, done4_q.size(), done6_q.size(), done8_q.size());
      end
      $display("test_random_keys[%0d]: key=%h w43=%h", it, k, w4[32*43 +: 32]);
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_nk4_vector();
    test_nk6_vector();
    test_nk8_vector();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    test_random_keys();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
